// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC accumulate controller.
package mac_pkg;

  localparam int PROD_W_DEF = 27;
  localparam int ACC_W_DEF  = 28;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/mac_acc_adder.sv
// Carry-select accumulate adder: sign-extends the product and adds it to the
// accumulator. The lower half ripples; the upper half is computed for both
// carry-in values and the low-half carry-out selects between them.
module mac_acc_adder
  import mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic signed [PROD_W-1:0] a_i,
  input  logic signed [ACC_W-1:0]  b_i,
  output logic signed [ACC_W-1:0]  sum_o
);

  localparam int LO_W = ACC_W / 2;
  localparam int HI_W = ACC_W - LO_W;

  logic [ACC_W-1:0] a_ext;
  logic [LO_W:0]    lo_sum;
  logic [HI_W-1:0]  hi_c0;
  logic [HI_W-1:0]  hi_c1;

  // Sign-extend, form both upper-half candidates and pick one by the low carry.
  always_comb begin
    a_ext  = {{(ACC_W-PROD_W){a_i[PROD_W-1]}}, a_i};
    lo_sum = {1'b0, a_ext[LO_W-1:0]} + {1'b0, b_i[LO_W-1:0]};
    hi_c0  = a_ext[ACC_W-1:LO_W] + b_i[ACC_W-1:LO_W];
    hi_c1  = a_ext[ACC_W-1:LO_W] + b_i[ACC_W-1:LO_W] + HI_W'(1);
    sum_o  = {(lo_sum[LO_W] ? hi_c1 : hi_c0), lo_sum[LO_W-1:0]};
  end

endmodule

// File: rtl/mac_accum_ctrl.sv
// Dot-product accumulate controller: takes len signed products over a
// valid/ready stream, sums them with wrap-around and a sticky overflow flag,
// then presents the result on a valid/ready result port.
//
// Handshakes: a beat moves on a rising edge where valid and ready are both 1.
// Ready/valid outputs of this block depend on the state register only, so a
// producer may wait for ready before raising valid without deadlock, and
// res/ovf hold steady while res_valid is high. abort overrides everything.
module mac_accum_ctrl
  import mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic        [CNT_W-1:0]  len,
  input  logic                     abort,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  input  logic signed [PROD_W-1:0] prod,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [ACC_W-1:0]  res,
  output logic                     ovf,
  output logic                     busy,
  output logic        [1:0]        dbg_state
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic signed [ACC_W-1:0] sum;
  logic                    xfer;
  logic                    ovf_hit;

  mac_acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .a_i   (prod),
    .b_i   (acc_q),
    .sum_o (sum)
  );

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state: start only in IDLE, abort wins in ACCUM/DONE.
  always_comb begin
    state_d = state_q;
    xfer    = (state_q == ST_ACCUM) && prod_valid && !abort;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (len == '0) ? ST_DONE : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (abort)                            state_d = ST_IDLE;
        else if (xfer && cnt_q == CNT_W'(1))  state_d = ST_DONE;
      end
      ST_DONE: begin
        if (abort || res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: clear on job start, accumulate and count down per transfer.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ovf_hit = (prod[PROD_W-1] == acc_q[ACC_W-1]) &&
              (sum[ACC_W-1] != prod[PROD_W-1]);
    if (state_q == ST_IDLE && start) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = len;
    end else if (xfer) begin
      acc_d = sum;
      cnt_d = cnt_q - CNT_W'(1);
      if (ovf_hit) ovf_d = 1'b1;
    end
  end

  // Outputs decoded from the state register only.
  always_comb begin
    prod_ready = (state_q == ST_ACCUM);
    res_valid  = (state_q == ST_DONE);
    busy       = (state_q != ST_IDLE);
    res        = acc_q;
    ovf        = ovf_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Bench for mac_accum_ctrl: directed jobs, a per-cycle comparison against a
// transaction-level model, and literal expectations for each scenario.
module tb_mac_accum_ctrl;

  localparam int PW = 27;
  localparam int AW = 28;
  localparam int CW = 8;
  localparam longint ACC_MAX = (longint'(1) <<< (AW-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (AW-1));
  localparam longint SPAN    = longint'(1) <<< AW;
  localparam int P_IDLE = 0, P_ACCUM = 1, P_DONE = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, abort, prod_valid, res_ready;
  logic [CW-1:0] len;
  logic [PW-1:0] prod;
  logic          prod_ready, res_valid, ovf, busy;
  logic [AW-1:0] res;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  mac_accum_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod       (prod),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res        (res),
    .ovf        (ovf),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: job phase, exact running sum folded into ACC_W range
  int     m_phase;
  longint m_acc;
  bit     m_ovf;
  int     m_left;

  always @(posedge clk or negedge rst_n) begin : model
    longint t;
    if (!rst_n) begin
      m_phase <= P_IDLE;
      m_acc   <= 0;
      m_ovf   <= 1'b0;
      m_left  <= 0;
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin
          m_acc   <= 0;
          m_ovf   <= 1'b0;
          m_left  <= int'(len);
          m_phase <= (len == 0) ? P_DONE : P_ACCUM;
        end
        P_ACCUM: begin
          if (abort) m_phase <= P_IDLE;
          else if (prod_valid) begin
            t = m_acc + longint'($signed(prod));
            if (t > ACC_MAX || t < ACC_MIN) m_ovf <= 1'b1;
            if (t > ACC_MAX) t = t - SPAN;
            else if (t < ACC_MIN) t = t + SPAN;
            m_acc  <= t;
            m_left <= m_left - 1;
            if (m_left == 1) m_phase <= P_DONE;
          end
        end
        default: if (abort || res_ready) m_phase <= P_IDLE;
      endcase
    end
  end

  // transfer monitor on the DUT port
  int dut_xfers = 0;
  always @(posedge clk)
    if (rst_n && prod_valid && prod_ready && !abort) dut_xfers <= dut_xfers + 1;

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_prod_ready", prod_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
    end else begin
      chk("prod_ready", prod_ready, m_phase == P_ACCUM);
      chk("res_valid", res_valid, m_phase == P_DONE);
      chk("busy", busy, m_phase != P_IDLE);
      if (m_phase == P_DONE) begin
        chk("res", res, m_acc[AW-1:0]);
        chk("ovf", ovf, m_ovf);
      end
    end
  end

  // driver tasks (inputs change 1 time unit after the rising edge)
  task automatic start_job(input int l);
    start = 1'b1;
    len   = CW'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_prod(input logic [PW-1:0] p, input int bubbles);
    int guard;
    prod_valid = 1'b0;
    for (int i = 0; i < bubbles; i++) begin @(posedge clk); #1; end
    prod_valid = 1'b1;
    prod       = p;
    guard      = 0;
    while (!prod_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    if (guard >= 20) chk("xfer_timeout", 1, 0);
    @(posedge clk); #1;
    prod_valid = 1'b0;
  endtask

  task automatic wait_result(input int hold, input bit with_start,
                             output logic [AW-1:0] r, output logic o);
    int guard = 0;
    res_ready = 1'b0;
    while (!res_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    if (guard >= 50) chk("res_timeout", 1, 0);
    for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
    r         = res;
    o         = ovf;
    res_ready = 1'b1;
    if (with_start) begin start = 1'b1; len = CW'(3); end
    @(posedge clk); #1;
    res_ready = 1'b0;
    start     = 1'b0;
  endtask

  logic [AW-1:0] r;
  logic          o;
  int            x0;

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
    prod_valid = 1'b0; prod = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_res", res, 0);
    chk("reset_ovf", ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // three products, no bubbles; start during the DONE handshake is ignored
    start_job(3);
    send_prod(27'd5, 0);
    send_prod(-27'sd2, 0);
    send_prod(27'd7, 0);
    chk("lat_res_valid", res_valid, 1);
    wait_result(0, 1'b1, r, o);
    chk("sum3_res", r, 28'd10);
    chk("sum3_ovf", o, 0);
    chk("start_in_done_ignored", busy, 0);

    // max-positive products: no overflow for two, wrap for three
    start_job(2);
    send_prod(27'h3FFFFFF, 0);
    send_prod(27'h3FFFFFF, 0);
    wait_result(0, 1'b0, r, o);
    chk("max2_res", r, 28'h7FFFFFE);
    chk("max2_ovf", o, 0);
    start_job(3);
    for (int i = 0; i < 3; i++) send_prod(27'h3FFFFFF, 0);
    wait_result(0, 1'b0, r, o);
    chk("max3_res", r, 28'hBFFFFFD);
    chk("max3_ovf", o, 1);

    // zero-length job goes straight to DONE
    start_job(0);
    chk("len0_res_valid", res_valid, 1);
    chk("len0_prod_ready", prod_ready, 0);
    wait_result(0, 1'b0, r, o);
    chk("len0_res", r, 28'd0);

    // bubbles and a stalled result port
    x0 = dut_xfers;
    start_job(4);
    send_prod(27'd1000, $urandom_range(0, 3));
    send_prod(-27'sd3000, $urandom_range(0, 3));
    send_prod(27'd123456, $urandom_range(0, 3));
    send_prod(-27'sd7, $urandom_range(0, 3));
    wait_result(5, 1'b0, r, o);
    chk("bubble_res", r, 28'd121449);
    chk("bubble_xfers", dut_xfers - x0, 4);

    // abort after two of four transfers, with a product offered
    x0 = dut_xfers;
    start_job(4);
    send_prod(27'd100, 0);
    send_prod(27'd200, 0);
    prod_valid = 1'b1; prod = 27'd999; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; prod_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_xfers", dut_xfers - x0, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_res", res_valid, 0);
    start_job(1);
    send_prod(-27'sd1, 1);
    wait_result(0, 1'b0, r, o);
    chk("after_abort_res", r, 28'hFFFFFFF);
    chk("after_abort_ovf", o, 0);

    // asynchronous reset between edges in the middle of a job
    start_job(3);
    send_prod(27'd9, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_prod_ready", prod_ready, 0);
    chk("async_res_valid", res_valid, 0);
    chk("async_res", res, 0);
    chk("async_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle", busy, 0);
    start_job(2);
    send_prod(27'd3, 0);
    send_prod(27'd4, 2);
    wait_result(1, 1'b0, r, o);
    chk("post_rst_res", r, 28'd7);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    chk("global_timeout", 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
